// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and flag bundle for multicycle_alu.
package alu_pkg;

  localparam logic [3:0] OP_MULU = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_NOTA = 4'b0011;
  localparam logic [3:0] OP_NEGA = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_NOP  = 4'b1010;
  localparam logic [3:0] OP_DIVU = 4'b1011;
  localparam logic [3:0] OP_SLT  = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ITER   = 2'd1,
    ST_FINISH = 2'd2
  } alu_state_e;

  typedef struct packed {
    logic carry;
    logic overflow;
  } alu_flags_t;

endpackage

// File: rtl/multicycle_alu_if.sv
// Request/result bundle between the execute-stage control unit (master) and multicycle_alu (slave).
interface multicycle_alu_if #(
  parameter int WORD_LENGTH = 32
);
  logic                   start;
  logic [3:0]             control;
  logic [WORD_LENGTH-1:0] dataA;
  logic [WORD_LENGTH-1:0] dataB;
  logic                   busy;
  logic                   done;
  logic [WORD_LENGTH-1:0] dataC;
  logic [WORD_LENGTH-1:0] dataHi;
  logic                   carry;
  logic                   overflow;
  logic                   zero;

  modport master (
    output start, control, dataA, dataB,
    input  busy, done, dataC, dataHi, carry, overflow, zero
  );

  modport slave (
    input  start, control, dataA, dataB,
    output busy, done, dataC, dataHi, carry, overflow, zero
  );
endinterface

// File: rtl/alu_iter_unit.sv
// W-step shift/add multiplier and (with MULTICYCLE_ALU_DIV_EN) restoring divider sharing one register pair.
// hi_next/lo_next are the values after the current step; 'last' flags the final step.
module alu_iter_unit #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         mode,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic         last,
  output logic [W-1:0] hi_next,
  output logic [W-1:0] lo_next
);
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W:0]    mul_sum;
  logic [W-1:0]  mul_hi, mul_lo;

  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    mul_hi  = mul_sum[W:1];
    mul_lo  = {mul_sum[0], lo_q[W-1:1]};
  end

`ifdef MULTICYCLE_ALU_DIV_EN
  logic         mode_q;
  logic [W:0]   div_shift;
  logic         div_ge;
  logic [W-1:0] div_hi, div_lo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      mode_q <= 1'b0;
    else if (start) mode_q <= mode;
  end

  // A zero divisor always "fits", so the quotient fills with ones and A shifts into the remainder.
  always_comb begin
    div_shift = {hi_q, lo_q[W-1]};
    div_ge    = (div_shift >= {1'b0, b_q});
    div_hi    = div_ge ? W'(div_shift - {1'b0, b_q}) : div_shift[W-1:0];
    div_lo    = {lo_q[W-2:0], div_ge};
    hi_next   = mode_q ? div_hi : mul_hi;
    lo_next   = mode_q ? div_lo : mul_lo;
  end
`else
  logic unused_mode;
  assign unused_mode = mode;

  always_comb begin
    hi_next = mul_hi;
    lo_next = mul_lo;
  end
`endif

  assign last = (cnt_q == CW'(1));

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    b_d   = b_q;
    cnt_d = cnt_q;
    if (start) begin
      hi_d  = '0;
      lo_d  = op_a;
      b_d   = op_b;
      cnt_d = CW'(W);
    end else if (cnt_q != '0) begin
      hi_d  = hi_next;
      lo_d  = lo_next;
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/multicycle_alu.sv
// Registered ALU: single-cycle logic/add/shift ops, W-cycle MULU and DIVU (DIVU only with MULTICYCLE_ALU_DIV_EN).
//   state     | meaning
//   ST_IDLE   | waiting for start
//   ST_ITER   | multiply/divide stepping, busy high
//   ST_FINISH | done pulse, results valid
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WORD_LENGTH = 32,
  parameter int SHAMT_W     = $clog2(WORD_LENGTH)
) (
  input  logic            clk,
  input  logic            reset,
  multicycle_alu_if.slave bus
);
  localparam int W = WORD_LENGTH;

  alu_state_e   state_q, state_d;
  logic [W-1:0] data_c_q, data_c_d, data_hi_q, data_hi_d;
  alu_flags_t   flags_q, flags_d;
  logic         div_zero_q, div_zero_d;

  logic         accept, is_div, is_iter_op, iter_start, iter_last;
  logic [W-1:0] iter_hi, iter_lo;
  logic [W-1:0] sc_c;
  alu_flags_t   sc_flags;
  logic [W:0]   add_sum;
  logic [W-1:0] sub_diff;
  logic [SHAMT_W-1:0] shamt;

`ifdef MULTICYCLE_ALU_DIV_EN
  assign is_div = (bus.control == OP_DIVU);
`else
  assign is_div = 1'b0;
`endif

  // FINISH accepts a new start so single-cycle ops stream at one per cycle.
  assign is_iter_op = (bus.control == OP_MULU) || is_div;
  assign accept     = bus.start && (state_q != ST_ITER);
  assign iter_start = accept && is_iter_op;

  alu_iter_unit #(.W(W)) u_iter (
    .clk     (clk),
    .reset   (reset),
    .start   (iter_start),
    .mode    (is_div),
    .op_a    (bus.dataA),
    .op_b    (bus.dataB),
    .last    (iter_last),
    .hi_next (iter_hi),
    .lo_next (iter_lo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_FINISH: begin
        if (accept) state_d = is_iter_op ? ST_ITER : ST_FINISH;
        else        state_d = ST_IDLE;
      end
      ST_ITER:  if (iter_last) state_d = ST_FINISH;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == ST_ITER);
    bus.done = (state_q == ST_FINISH);
  end

  always_comb begin
    add_sum  = {1'b0, bus.dataA} + {1'b0, bus.dataB};
    sub_diff = bus.dataA - bus.dataB;
    shamt    = bus.dataB[SHAMT_W-1:0];
    sc_c     = '0;
    sc_flags = '0;
    case (bus.control)
      OP_SUB: begin
        sc_c              = sub_diff;
        sc_flags.carry    = (bus.dataA < bus.dataB);
        sc_flags.overflow = (bus.dataA[W-1] != bus.dataB[W-1]) && (sub_diff[W-1] != bus.dataA[W-1]);
      end
      OP_ADD: begin
        sc_c              = add_sum[W-1:0];
        sc_flags.carry    = add_sum[W];
        sc_flags.overflow = (bus.dataA[W-1] == bus.dataB[W-1]) && (add_sum[W-1] != bus.dataA[W-1]);
      end
      OP_NOTA: sc_c = ~bus.dataA;
      OP_NEGA: sc_c = '0 - bus.dataA;
      OP_AND:  sc_c = bus.dataA & bus.dataB;
      OP_OR:   sc_c = bus.dataA | bus.dataB;
      OP_XOR:  sc_c = bus.dataA ^ bus.dataB;
      OP_SLL:  sc_c = bus.dataA << shamt;
      OP_SRL:  sc_c = bus.dataA >> shamt;
      OP_SLT:  sc_c = {{(W-1){1'b0}}, ($signed(bus.dataA) < $signed(bus.dataB))};
      OP_MULU, OP_NOP, OP_DIVU: sc_c = '0;
      default: sc_c = '0;
    endcase
  end

  always_comb begin
    data_c_d   = data_c_q;
    data_hi_d  = data_hi_q;
    flags_d    = flags_q;
    div_zero_d = div_zero_q;
    if (iter_start) div_zero_d = is_div && (bus.dataB == '0);
    if (accept && !is_iter_op) begin
      data_c_d  = sc_c;
      data_hi_d = '0;
      flags_d   = sc_flags;
    end else if ((state_q == ST_ITER) && iter_last) begin
      data_c_d         = iter_lo;
      data_hi_d        = iter_hi;
      flags_d.carry    = div_zero_q;
      flags_d.overflow = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_c_q   <= '0;
      data_hi_q  <= '0;
      flags_q    <= '0;
      div_zero_q <= 1'b0;
    end else begin
      data_c_q   <= data_c_d;
      data_hi_q  <= data_hi_d;
      flags_q    <= flags_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.dataC    = data_c_q;
  assign bus.dataHi   = data_hi_q;
  assign bus.carry    = flags_q.carry;
  assign bus.overflow = flags_q.overflow;
  assign bus.zero     = (data_c_q == '0) && (data_hi_q == '0);
endmodule
